sim_end_monitor: RTL and testbench

- Synthesizable, parametrised end-of-simulation controller. It is instantiated in the test harness between the DUT's per-agent status signals and the top-level driver.
- It aggregates success and failure from N channels, enforces a runtime cycle limit, and detects hangs with a progress watchdog.
- After success it waits a drain window, then raises a finish request carrying a coded reason, so the driver (plain or UVM) only has to observe one handshake.

---
 rtl/sim_end_pkg.sv | 29 ++
 rtl/sim_end_idle_watchdog.sv | 40 ++++
 rtl/sim_end_monitor.sv | 132 +++++++++++++
 tb/tb_sim_end_monitor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_end_pkg.sv
// Shared types and helpers for the end-of-simulation monitor.
// Finish reasons are encoded so a driver can decode them directly.
package sim_end_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        FAILURE = 2'd1,
        TIMEOUT = 2'd2,
        HANG    = 2'd3
    } reason_e;

    // Scans from the top so the lowest set bit is the one that survives.
    function automatic int unsigned lowest_set_index(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sim_end_idle_watchdog.sv
// Saturating idle counter that flags a hang when no kick arrives for
// WATCHDOG_CYCLES enabled cycles; WATCHDOG_CYCLES == 0 disables it.
module sim_end_idle_watchdog #(
    parameter int unsigned WATCHDOG_CYCLES = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int IW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [IW-1:0] LIMIT = IW'((WATCHDOG_CYCLES > 0) ? WATCHDOG_CYCLES - 1 : 0);

    logic [IW-1:0] idle_q;
    logic [IW-1:0] idle_d;

    always_comb begin
        idle_d = idle_q;
        if (enable) begin
            if (kick) begin
                idle_d = '0;
            end else if (idle_q != LIMIT) begin
                idle_d = idle_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign expired = (WATCHDOG_CYCLES != 0) && enable && !kick && (idle_q == LIMIT);

endmodule

// File: rtl/sim_end_monitor.sv
// End-of-simulation controller: aggregates per-channel success/failure,
// enforces a cycle limit and a hang watchdog, and raises one finish handshake.
module sim_end_monitor
    import sim_end_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS    = 4,
    parameter int unsigned COUNTER_WIDTH   = 64,
    parameter int unsigned WATCHDOG_CYCLES = 100000,
    parameter int unsigned DRAIN_CYCLES    = 16,
    localparam int FCW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [COUNTER_WIDTH-1:0] cfg_max_cycles,
    input  logic [NUM_CHANNELS-1:0]  chan_enable,
    input  logic [NUM_CHANNELS-1:0]  chan_success,
    input  logic [NUM_CHANNELS-1:0]  chan_failure,
    input  logic [NUM_CHANNELS-1:0]  chan_progress,
    output logic [NUM_CHANNELS-1:0]  success_seen,
    output logic [COUNTER_WIDTH-1:0] cycle_count,
    output logic                     finish_request,
    output logic                     pass,
    output logic                     fail,
    output logic [1:0]               fail_reason,
    output logic [FCW-1:0]           fail_channel
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_e                   state_q;
    reason_e                  reason_q;
    logic [NUM_CHANNELS-1:0]  success_seen_q;
    logic [COUNTER_WIDTH-1:0] cycle_q;
    logic [DW-1:0]            drain_q;
    logic                     pass_q;
    logic                     fail_q;
    logic                     finish_q;
    logic [FCW-1:0]           fchan_q;

    logic                     active;
    logic [NUM_CHANNELS-1:0]  fail_vec;
    logic [NUM_CHANNELS-1:0]  success_d;
    logic                     fail_hit;
    logic                     timeout;
    logic                     all_ok;
    logic                     hang;

    assign active    = (state_q == RUN) || (state_q == DRAIN);
    assign fail_vec  = chan_failure & chan_enable;
    assign fail_hit  = |fail_vec;
    assign timeout   = (cfg_max_cycles != '0) && (cycle_q >= cfg_max_cycles);
    // Same-cycle success counts toward completion, not just recorded history.
    assign success_d = success_seen_q | (chan_success & chan_enable);
    assign all_ok    = (&(success_d | ~chan_enable)) && (|chan_enable);

    sim_end_idle_watchdog #(
        .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .enable (state_q == RUN),
        .kick   (|(chan_progress & chan_enable)),
        .expired(hang)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_q        <= '0;
            success_seen_q <= '0;
        end else if (active) begin
            if (cycle_q != '1) cycle_q <= cycle_q + COUNTER_WIDTH'(1);
            success_seen_q <= success_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= RUN;
            reason_q <= NONE;
            drain_q  <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            finish_q <= 1'b0;
            fchan_q  <= '0;
        end else if (active) begin
            if (fail_hit) begin
                state_q  <= FAIL;
                fail_q   <= 1'b1;
                finish_q <= 1'b1;
                reason_q <= FAILURE;
                fchan_q  <= FCW'(lowest_set_index(32'(fail_vec)));
            end else if (timeout) begin
                state_q  <= FAIL;
                fail_q   <= 1'b1;
                finish_q <= 1'b1;
                reason_q <= TIMEOUT;
            end else if (hang) begin
                state_q  <= FAIL;
                fail_q   <= 1'b1;
                finish_q <= 1'b1;
                reason_q <= HANG;
            end else if (state_q == RUN) begin
                if (all_ok) begin
                    drain_q <= '0;
                    if (DRAIN_CYCLES == 0) begin
                        state_q  <= PASS;
                        pass_q   <= 1'b1;
                        finish_q <= 1'b1;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
            end else if (drain_q == DRAIN_LAST) begin
                state_q  <= PASS;
                pass_q   <= 1'b1;
                finish_q <= 1'b1;
            end else begin
                drain_q <= drain_q + DW'(1);
            end
        end
    end

    assign success_seen   = success_seen_q;
    assign cycle_count    = cycle_q;
    assign finish_request = finish_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign fail_reason    = reason_q;
    assign fail_channel   = fchan_q;

endmodule

// File: tb/tb_sim_end_monitor.sv
// Self-checking bench for sim_end_monitor: single-event vector table plus
// multi-cycle sequences, all checked through an expectation queue.
module tb_sim_end_monitor;

    logic        clock;
    logic        reset;
    logic [31:0] cfg_max_cycles;
    logic [3:0]  chan_enable;
    logic [3:0]  chan_success;
    logic [3:0]  chan_failure;
    logic [3:0]  chan_progress;
    logic [3:0]  success_seen;
    logic [31:0] cycle_count;
    logic        finish_request;
    logic        pass;
    logic        fail;
    logic [1:0]  fail_reason;
    logic [1:0]  fail_channel;

    int checks   = 0;
    int failures = 0;
    int edgeIdx  = 0;
    int kickPeriod = 4;
    logic kickOn = 1'b1;
    logic [3:0] kickMask = 4'b0000;

    typedef struct {
        logic       expPass;
        logic       expFail;
        logic [1:0] expReason;
        logic [1:0] expChan;
        logic [3:0] expSeen;
    } exp_t;

    typedef struct {
        logic [3:0] en;
        logic [3:0] succ;
        logic [3:0] failv;
        exp_t       exp;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[8];

    sim_end_monitor #(
        .NUM_CHANNELS   (4),
        .COUNTER_WIDTH  (32),
        .WATCHDOG_CYCLES(8),
        .DRAIN_CYCLES   (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cfg_max_cycles(cfg_max_cycles),
        .chan_enable   (chan_enable),
        .chan_success  (chan_success),
        .chan_failure  (chan_failure),
        .chan_progress (chan_progress),
        .success_seen  (success_seen),
        .cycle_count   (cycle_count),
        .finish_request(finish_request),
        .pass          (pass),
        .fail          (fail),
        .fail_reason   (fail_reason),
        .fail_channel  (fail_channel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Success/failure are single-cycle pulses; progress follows the kick schedule.
    task automatic stepCycle();
        edgeIdx++;
        chan_progress = (kickOn && (edgeIdx % kickPeriod == 0)) ? kickMask : 4'b0000;
        @(posedge clock);
        #1;
        chan_success = 4'b0000;
        chan_failure = 4'b0000;
    endtask

    task automatic stepN(input int n);
        for (int k = 0; k < n; k++) stepCycle();
    endtask

    task automatic applyReset();
        reset         = 1'b0;
        chan_success  = 4'b0000;
        chan_failure  = 4'b0000;
        chan_progress = 4'b0000;
        @(posedge clock);
        #1;
        reset   = 1'b1;
        edgeIdx = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] succ, input logic [3:0] failv);
        chan_success = succ;
        chan_failure = failv;
        stepCycle();
    endtask

    task automatic expectOut(input logic p, input logic f, input logic [1:0] r,
                             input logic [1:0] c, input logic [3:0] s);
        exp_t e;
        e.expPass = p; e.expFail = f; e.expReason = r; e.expChan = c; e.expSeen = s;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s.queue actual=empty required=entry", tag);
            return;
        end
        e = sbQ.pop_front();
        checkVal({tag, ".pass"},   64'(pass),           64'(e.expPass));
        checkVal({tag, ".fail"},   64'(fail),           64'(e.expFail));
        checkVal({tag, ".finish"}, 64'(finish_request), 64'(e.expPass | e.expFail));
        checkVal({tag, ".reason"}, 64'(fail_reason),    64'(e.expReason));
        checkVal({tag, ".chan"},   64'(fail_channel),   64'(e.expChan));
        checkVal({tag, ".seen"},   64'(success_seen),   64'(e.expSeen));
    endtask

    initial begin
        reset          = 1'b0;
        cfg_max_cycles = '0;
        chan_enable    = 4'b0000;
        chan_success   = 4'b0000;
        chan_failure   = 4'b0000;
        chan_progress  = 4'b0000;

        vecs[0] = '{4'b0101, 4'b0101, 4'b0000, '{1'b0, 1'b0, 2'd0, 2'd0, 4'b0101}};
        vecs[1] = '{4'b1111, 4'b1111, 4'b1100, '{1'b0, 1'b1, 2'd1, 2'd2, 4'b1111}};
        vecs[2] = '{4'b0011, 4'b0000, 4'b1100, '{1'b0, 1'b0, 2'd0, 2'd0, 4'b0000}};
        vecs[3] = '{4'b1111, 4'b0000, 4'b1010, '{1'b0, 1'b1, 2'd1, 2'd1, 4'b0000}};
        vecs[4] = '{4'b1000, 4'b0000, 4'b1000, '{1'b0, 1'b1, 2'd1, 2'd3, 4'b0000}};
        vecs[5] = '{4'b0000, 4'b1111, 4'b0000, '{1'b0, 1'b0, 2'd0, 2'd0, 4'b0000}};
        vecs[6] = '{4'b0001, 4'b0001, 4'b0001, '{1'b0, 1'b1, 2'd1, 2'd0, 4'b0001}};
        vecs[7] = '{4'b0110, 4'b0010, 4'b0100, '{1'b0, 1'b1, 2'd1, 2'd2, 4'b0010}};

        // Reset state
        chan_enable = 4'b0001;
        kickMask    = 4'b0001;
        applyReset();
        expectOut(1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        checkOutput("reset");
        checkVal("reset.count", 64'(cycle_count), 64'd0);

        // Single-event vectors, each from a fresh reset
        for (int i = 0; i < 8; i++) begin
            chan_enable = vecs[i].en;
            kickMask    = vecs[i].en;
            applyReset();
            sbQ.push_back(vecs[i].exp);
            applyStimulus(vecs[i].succ, vecs[i].failv);
            checkOutput($sformatf("vec%0d", i));
        end

        // Pass with drain: ch0 at edge 11, ch2 at edge 21, PASS after edge 37
        chan_enable = 4'b0101;
        kickMask    = 4'b0101;
        applyReset();
        for (int e = 1; e <= 37; e++) begin
            if (e == 11) chan_success = 4'b0001;
            if (e == 21) chan_success = 4'b0100;
            stepCycle();
            if (e == 21) begin
                expectOut(1'b0, 1'b0, 2'd0, 2'd0, 4'b0101);
                checkOutput("drain.enter");
            end
            if (e == 36) begin
                expectOut(1'b0, 1'b0, 2'd0, 2'd0, 4'b0101);
                checkOutput("drain.last");
            end
        end
        expectOut(1'b1, 1'b0, 2'd0, 2'd0, 4'b0101);
        checkOutput("pass");
        checkVal("pass.count", 64'(cycle_count), 64'd37);
        stepN(5);
        checkVal("pass.frozen", 64'(cycle_count), 64'd37);

        // Timeout at 50
        chan_enable    = 4'b0001;
        kickMask       = 4'b0001;
        cfg_max_cycles = 32'd50;
        applyReset();
        stepN(50);
        expectOut(1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        checkOutput("tmo.before");
        checkVal("tmo.count50", 64'(cycle_count), 64'd50);
        stepCycle();
        expectOut(1'b0, 1'b1, 2'd2, 2'd0, 4'b0000);
        checkOutput("tmo");
        stepN(3);
        checkVal("tmo.frozen", 64'(cycle_count), 64'd51);

        // Timeout and success in the same cycle
        cfg_max_cycles = 32'd5;
        applyReset();
        stepN(5);
        applyStimulus(4'b0001, 4'b0000);
        expectOut(1'b0, 1'b1, 2'd2, 2'd0, 4'b0001);
        checkOutput("tmo.succ");
        stepN(20);
        expectOut(1'b0, 1'b1, 2'd2, 2'd0, 4'b0001);
        checkOutput("tmo.succ.hold");

        // No limit: 10000 cycles without a timeout
        cfg_max_cycles = 32'd0;
        applyReset();
        stepN(10000);
        checkVal("nolimit.fail", 64'(fail), 64'd0);
        checkVal("nolimit.count", 64'(cycle_count), 64'd10000);

        // Hang: progress only on a disabled channel
        chan_enable = 4'b0001;
        kickMask    = 4'b0010;
        applyReset();
        stepN(7);
        checkVal("hang.before", 64'(fail), 64'd0);
        stepCycle();
        expectOut(1'b0, 1'b1, 2'd3, 2'd0, 4'b0000);
        checkOutput("hang");

        // Kicks every 7 cycles on an enabled channel keep the watchdog quiet
        kickMask   = 4'b0001;
        kickPeriod = 7;
        applyReset();
        stepN(100);
        checkVal("kick7.fail", 64'(fail), 64'd0);
        kickPeriod = 4;

        // Failure on the last drain cycle; no kicks, so the watchdog must stay frozen in DRAIN
        chan_enable = 4'b0011;
        kickOn      = 1'b0;
        applyReset();
        stepN(2);
        applyStimulus(4'b0011, 4'b0000);
        stepN(15);
        expectOut(1'b0, 1'b0, 2'd0, 2'd0, 4'b0011);
        checkOutput("dfail.before");
        applyStimulus(4'b0000, 4'b0010);
        expectOut(1'b0, 1'b1, 2'd1, 2'd1, 4'b0011);
        checkOutput("dfail");
        stepN(20);
        checkVal("dfail.nopass", 64'(pass), 64'd0);
        kickOn = 1'b1;

        // Reset out of FAIL, then a clean pass
        chan_enable = 4'b0001;
        kickMask    = 4'b0001;
        applyReset();
        expectOut(1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        checkOutput("rst.fromfail");
        checkVal("rst.count", 64'(cycle_count), 64'd0);
        stepCycle();
        checkVal("rst.count1", 64'(cycle_count), 64'd1);
        applyStimulus(4'b0001, 4'b0000);
        stepN(15);
        checkVal("rst.nopass", 64'(pass), 64'd0);
        stepCycle();
        expectOut(1'b1, 1'b0, 2'd0, 2'd0, 4'b0001);
        checkOutput("rst.pass");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
